taylor_trig_unit: RTL
=====================

# taylor_trig_unit

Self-sequenced fixed-point cosine/sine evaluator for the CA 6 arithmetic datapath. It computes cos(x) or sin(x) by Maclaurin series, using an internal FSM, term counter and elaboration-time coefficient ROM. Width, fraction bits and maximum term count are parametrised. A magnitude threshold allows early termination. The host uses a start/busy/done handshake.

## Interface
- WIDTH, 16: data width of x, thr, result and internal registers.
- FRAC, 8: fraction bits. All operands are fixed-point with FRAC fractional bits, so 1.0 = 2^FRAC.
- TERMS, 8: maximum series terms including term 0. Must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only in IDLE.
- mode  in  1  0 = cos, 1 = sin. Sampled with start.
- x  in  WIDTH  unsigned argument. Sampled with start.
- thr  in  WIDTH  unsigned stop threshold. Sampled with start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in FIN.
- result  out  WIDTH  two's-complement sum.
- terms_used  out  $clog2(TERMS+1)  count of terms accumulated, including term 0.

## Operation
- States and transitions:
  - IDLE: on start, go to SQR.
  - SQR → MULX → MULC → ACC.
  - ACC → MULX (continue) or FIN (stop).
  - FIN → IDLE.
- Accept (IDLE & start) performs these loads:
  - Latch x, thr and mode.
  - term ← (mode ? x : 2^FRAC); result ← same value.
  - k ← 1; terms_used ← 1.
- SQR: x2 ← (x·x)[WIDTH+FRAC-1:FRAC].
- MULX: term ← (term·x2)[WIDTH+FRAC-1:FRAC].
- MULC: term ← (term·c(mode,k))[WIDTH+FRAC-1:FRAC].
- Coefficient ROM, computed by a function at elaboration:
  - cos: c = round(2^FRAC / ((2k-1)(2k))).
  - sin: c = round(2^FRAC / ((2k)(2k+1))).
  - Rounding is integer (2^FRAC + d/2) / d.
- ACC:
  - If term ≤ thr: result unchanged; go to FIN.
  - Otherwise: result ← k odd ? result − term : result + term, and terms_used increments.
  - Then, if k == TERMS−1, go to FIN; else k++ and go to MULX.
- All products are unsigned 2·WIDTH wide and truncated, with no rounding.
- result add/subtract wraps modulo 2^WIDTH; there is no saturation.
- Out-of-range x (above about π/2) is not flagged. The output is simply whatever the truncated arithmetic yields.
- start while busy (including during FIN) is ignored; latched operands are unaffected.
- result and terms_used are valid from the done cycle until the next accepted start, and hold in IDLE.
- thr = 0 stops at the first zero term.

## Timing
- Reset values: busy=0, done=0, result=0, terms_used=0; state IDLE. Internal term, x2 and k are also 0.
- Reset in any state returns to IDLE on that edge. The in-flight computation is discarded, and no done pulse is produced.
- Numbering: start is sampled in cycle 0; SQR occupies cycle 1.
- Iteration k occupies cycles 3k−1 (MULX), 3k (MULC) and 3k+1 (ACC).
- Stop in ACC of iteration m: done=1 in cycle 3m+2, back in IDLE in cycle 3m+3. A new start is accepted in cycle 3m+3.
- Worst case: done in cycle 3(TERMS−1)+2, which is 23 for TERMS=8.
- busy is high in cycles 1 … done cycle inclusive, and low in IDLE.

## Test plan
All scenarios use WIDTH=16, FRAC=8, TERMS=8 unless stated.

1. cos, x=256 (1.0), thr=0:
   - Terms run 256, 128, 10, 0.
   - Required: result=138, terms_used=3, done in cycle 11, busy high in cycles 1–11.
2. sin, x=256, thr=0:
   - Coefficients 43, 13, 6.
   - Required: result=215, terms_used=3, done in cycle 11.
3. cos, x=256, thr=20:
   - Iteration 2 term=10 ≤ 20.
   - Required: result=128, terms_used=2, done in cycle 8.
4. TERMS=3, cos, x=256, thr=0:
   - The term limit ends the run after iteration 2.
   - Required: result=138, terms_used=3, done in cycle 8.
5. cos, x=0, thr=0:
   - Required: result=256, terms_used=1, done in cycle 5.
   - A second start with x=512 applied in cycles 2–5 is ignored.
   - A start in cycle 6 is accepted.
6. Reset and edge cases:
   - rst asserted in cycle 6 of scenario 1: next cycle busy=0, result=0, terms_used=0, and no done pulse.
   - A following sin, x=0 request yields result=0, terms_used=1, done in cycle 5.

Source files
------------

// File: rtl/taylor_trig_unit.sv
// Sequential fixed-point cos/sin evaluator by Maclaurin series.
// One shared truncating multiplier is stepped through SQR/MULX/MULC, and the terms are accumulated in ACC.
module taylor_trig_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int TERMS = 8,
    localparam int TUW  = $clog2(TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] thr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [TUW-1:0]   terms_used
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_SQR, S_MULX, S_MULC, S_ACC, S_FIN} state_t;

    // Slot k holds c(mode,k). Slot 0 is unused because term 0 needs no coefficient.
    function automatic logic [TERMS*WIDTH-1:0] build_rom(input logic is_sin);
        logic [TERMS*WIDTH-1:0] rom;
        int d;
        rom = '0;
        for (int k = 1; k < TERMS; k++) begin
            d = is_sin ? (2 * k) * (2 * k + 1) : (2 * k - 1) * (2 * k);
            rom[k*WIDTH +: WIDTH] = WIDTH'(((1 << FRAC) + d / 2) / d);
        end
        return rom;
    endfunction

    localparam logic [TERMS*WIDTH-1:0] COS_ROM = build_rom(1'b0);
    localparam logic [TERMS*WIDTH-1:0] SIN_ROM = build_rom(1'b1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, thr_q, thr_d, term_q, term_d, x2_q, x2_d, result_q, result_d;
    logic             mode_q, mode_d;
    logic [TUW-1:0]   k_q, k_d, terms_used_q, terms_used_d;
    logic [WIDTH-1:0] mul_a, mul_b, prod, coef, init_term;

    always_comb begin
        coef = mode_q ? SIN_ROM[int'(k_q)*WIDTH +: WIDTH] : COS_ROM[int'(k_q)*WIDTH +: WIDTH];
        unique case (state_q)
            S_SQR:   begin mul_a = x_q;    mul_b = x_q;  end
            S_MULX:  begin mul_a = term_q; mul_b = x2_q; end
            default: begin mul_a = term_q; mul_b = coef; end
        endcase
        prod      = WIDTH'((PW'(mul_a) * PW'(mul_b)) >> FRAC);
        init_term = mode ? x : WIDTH'(1 << FRAC);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        thr_d        = thr_q;
        mode_d       = mode_q;
        term_d       = term_q;
        x2_d         = x2_q;
        result_d     = result_q;
        k_d          = k_q;
        terms_used_d = terms_used_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                x_d          = x;
                thr_d        = thr;
                mode_d       = mode;
                term_d       = init_term;
                result_d     = init_term;
                k_d          = TUW'(1);
                terms_used_d = TUW'(1);
                state_d      = S_SQR;
            end
            S_SQR: begin
                x2_d    = prod;
                state_d = S_MULX;
            end
            S_MULX: begin
                term_d  = prod;
                state_d = S_MULC;
            end
            S_MULC: begin
                term_d  = prod;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (term_q <= thr_q) begin
                    state_d = S_FIN;
                end else begin
                    // Odd k carries the negative sign: -x^2/2!, -x^3/3!, ...
                    result_d     = k_q[0] ? result_q - term_q : result_q + term_q;
                    terms_used_d = terms_used_q + TUW'(1);
                    if (k_q == TUW'(TERMS - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        k_d     = k_q + TUW'(1);
                        state_d = S_MULX;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            thr_q        <= '0;
            mode_q       <= 1'b0;
            term_q       <= '0;
            x2_q         <= '0;
            result_q     <= '0;
            k_q          <= '0;
            terms_used_q <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            thr_q        <= thr_d;
            mode_q       <= mode_d;
            term_q       <= term_d;
            x2_q         <= x2_d;
            result_q     <= result_d;
            k_q          <= k_d;
            terms_used_q <= terms_used_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign result     = result_q;
    assign terms_used = terms_used_q;
endmodule
